// File: rtl/encoder_param_pkg.sv
// Shared types and arithmetic for the encoder parameter controller.
package encoder_param_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    NOTIFY = 2'd2
  } state_t;

  // Wide signed add followed by a clamp, used for both values and the step accumulator
  function automatic int add_clamp(input int x, input int y, input int lo, input int hi);
    int s;
    s = x + y;
    if (s < lo) s = lo;
    else if (s > hi) s = hi;
    return s;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Push-switch conditioning: 2-flop synchronizer, stability counter, one-cycle press pulse.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_sync;
  logic             r_cand;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync   <= 2'b11;
      r_cand   <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_sw};
      r_press <= 1'b0;
      // Any change of the synced level restarts the stability window
      if (r_sync[1] != r_cand) begin
        r_cand <= r_sync[1];
        r_cnt  <= '0;
      end else if (r_cand != r_stable) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= r_cand;
          r_press  <= ~r_cand;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/encoder_param_controller.sv
// Rotary encoder shared across NUM_PARAMS saturating parameter registers,
// with a valid/ready update channel toward the display writer.
module encoder_param_controller
  import encoder_param_pkg::*;
#(
  parameter int NUM_PARAMS      = 4,
  parameter int VAL_W           = 8,
  parameter int MAX_VAL         = 255,
  parameter int INIT_VAL        = 0,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PEND_MAX        = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a,
  input  logic                          b,
  input  logic                          sw,
  output logic [$clog2(NUM_PARAMS)-1:0] sel,
  output logic [NUM_PARAMS*VAL_W-1:0]   values,
  output logic                          upd_valid,
  input  logic                          upd_ready,
  output logic [$clog2(NUM_PARAMS)-1:0] upd_idx,
  output logic [VAL_W-1:0]              upd_value
);

  localparam int SEL_W  = $clog2(NUM_PARAMS);
  localparam int PEND_W = $clog2(PEND_MAX + 1) + 1;

  logic [1:0]               r_a_sync;
  logic [1:0]               r_b_sync;
  logic                     r_prev_a;
  state_t                   r_state;
  logic [SEL_W-1:0]         r_sel;
  logic signed [PEND_W-1:0] r_pend;
  logic [VAL_W-1:0]         r_val [NUM_PARAMS];
  logic                     r_upd_valid;
  logic [SEL_W-1:0]         r_upd_idx;
  logic [VAL_W-1:0]         r_upd_value;

  logic             w_press;
  logic             w_detent;
  int               w_step;
  logic [VAL_W-1:0] w_cur;
  logic [VAL_W-1:0] w_new;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debouncer (
    .clk    (clk),
    .reset  (reset),
    .i_sw   (sw),
    .o_press(w_press)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a_sync <= 2'b11;
      r_b_sync <= 2'b11;
      r_prev_a <= 1'b1;
    end else begin
      r_a_sync <= {r_a_sync[0], a};
      r_b_sync <= {r_b_sync[0], b};
      r_prev_a <= r_a_sync[1];
    end
  end

  assign w_detent = r_a_sync[1] & ~r_prev_a;

  always_comb begin
    w_step = 0;
    if (w_detent) w_step = r_b_sync[1] ? 1 : -1;
    w_cur = r_val[r_sel];
    w_new = VAL_W'(add_clamp(int'(w_cur), int'(r_pend), 0, MAX_VAL));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_pend      <= '0;
      r_upd_valid <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_value <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) r_val[i] <= VAL_W'(INIT_VAL);
    end else begin
      // A press discards any pending steps, including a detent in the same cycle
      if (w_press) begin
        r_sel  <= (r_sel == SEL_W'(NUM_PARAMS - 1)) ? '0 : r_sel + 1'b1;
        r_pend <= '0;
      end else if (r_state == APPLY) begin
        r_pend <= PEND_W'(w_step);
      end else begin
        r_pend <= PEND_W'(add_clamp(int'(r_pend), w_step, -PEND_MAX, PEND_MAX));
      end

      case (r_state)
        IDLE: begin
          if (r_pend != '0) r_state <= APPLY;
        end
        APPLY: begin
          r_val[r_sel] <= w_new;
          if (w_new == w_cur) begin
            r_state <= IDLE;
          end else begin
            r_upd_idx   <= r_sel;
            r_upd_value <= w_new;
            r_upd_valid <= 1'b1;
            r_state     <= NOTIFY;
          end
        end
        NOTIFY: begin
          if (upd_ready) begin
            r_upd_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_values
    assign values[g*VAL_W +: VAL_W] = r_val[g];
  end

  assign sel       = r_sel;
  assign upd_valid = r_upd_valid;
  assign upd_idx   = r_upd_idx;
  assign upd_value = r_upd_value;

endmodule
